// File: rtl/cache_ctrl.sv
// cache_ctrl: direct-mapped, write-through, no-write-allocate cache controller
// sitting between a CPU port and a word-burst RAM.
// Optional feature macro: CACHE_STATS_EN enables the saturating read hit/miss counters.
// Without the macro, hit_cnt and miss_cnt are tied to zero.

module cache_ctrl #(
    parameter int unsigned LINES   = 16,
    parameter int unsigned WR_HOLD = 2
) (
    input  logic        clk,
    input  logic        clr,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic        cpu_rd,
    input  logic        cpu_wr,
    output logic [31:0] cpu_rdata,
    output logic        cpu_ready,
    output logic [31:0] AB,
    output logic [31:0] DB,
    output logic        MWr,
    output logic        MRd,
    input  logic [31:0] MD,
    output logic [15:0] hit_cnt,
    output logic [15:0] miss_cnt
);

    localparam int unsigned IDXW  = $clog2(LINES);
    localparam int unsigned TAGW  = 28 - IDXW;
    localparam int unsigned HOLDW = $clog2(WR_HOLD + 1);

    typedef enum logic [2:0] {
        StIdle,
        StFill,
        StResp,
        StWrite,
        StDone
    } state_t;

    state_t              r_state;
    logic [31:0]         r_rdata;
    logic                r_ready;
    logic [31:0]         r_ab;
    logic [31:0]         r_db;
    logic                r_mwr;
    logic                r_mrd;
    logic [2:0]          r_fill_cnt;
    logic [HOLDW-1:0]    r_hold;
    logic [IDXW-1:0]     r_idx;
    logic [1:0]          r_word;
    logic [TAGW-1:0]     r_tag_l;
    logic [LINES-1:0]    r_valid;

    // Line storage: only the valid bits are reset.
    logic [31:0]         r_data [LINES][4];
    logic [TAGW-1:0]     r_tag  [LINES];

    logic [IDXW-1:0]     w_idx;
    logic [TAGW-1:0]     w_tag;
    logic [1:0]          w_word;
    logic                w_hit;
    logic [1:0]          w_fill_word;
    logic                w_arr_we;
    logic [IDXW-1:0]     w_arr_idx;
    logic [1:0]          w_arr_word;
    logic [31:0]         w_arr_wdata;
    logic                w_tag_we;
    logic                w_unused;

    assign w_idx    = cpu_addr[4 +: IDXW];
    assign w_tag    = cpu_addr[31 -: TAGW];
    assign w_word   = cpu_addr[3:2];
    assign w_hit    = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    // Byte offset within a word has no effect: accesses are whole words.
    assign w_unused = ^cpu_addr[1:0];

    // Fill counter 1..4 maps to line words 0..3 (MD lags MRd by one cycle).
    assign w_fill_word = 2'(r_fill_cnt - 3'd1);
    assign w_tag_we    = (r_state == StFill) && (r_fill_cnt == 3'd4);

    // Select the array write source: a CPU write hit or a refill beat.
    always_comb begin
        w_arr_we    = 1'b0;
        w_arr_idx   = w_idx;
        w_arr_word  = w_word;
        w_arr_wdata = cpu_wdata;
        if (r_state == StIdle && cpu_wr && w_hit) begin
            w_arr_we = 1'b1;
        end else if (r_state == StFill && r_fill_cnt != 3'd0) begin
            w_arr_we    = 1'b1;
            w_arr_idx   = r_idx;
            w_arr_word  = w_fill_word;
            w_arr_wdata = MD;
        end
    end

    // Tag/data array update, no reset.
    always_ff @(posedge clk) begin
        if (w_arr_we) begin
            r_data[w_arr_idx][w_arr_word] <= w_arr_wdata;
        end
        if (w_tag_we) begin
            r_tag[r_idx] <= r_tag_l;
        end
    end

    // Main controller FSM with registered CPU and RAM outputs.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_state    <= StIdle;
            r_rdata    <= '0;
            r_ready    <= 1'b0;
            r_ab       <= '0;
            r_db       <= '0;
            r_mwr      <= 1'b0;
            r_mrd      <= 1'b1;
            r_fill_cnt <= '0;
            r_hold     <= '0;
            r_idx      <= '0;
            r_word     <= '0;
            r_tag_l    <= '0;
            r_valid    <= '0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    r_ready <= 1'b0;
                    if (cpu_wr) begin
                        r_ab    <= {cpu_addr[31:2], 2'b00};
                        r_db    <= cpu_wdata;
                        r_mwr   <= 1'b1;
                        r_hold  <= HOLDW'(1);
                        r_state <= StWrite;
                    end else if (cpu_rd) begin
                        r_idx   <= w_idx;
                        r_word  <= w_word;
                        r_tag_l <= w_tag;
                        if (w_hit) begin
                            r_rdata <= r_data[w_idx][w_word];
                            r_ready <= 1'b1;
                            r_state <= StDone;
                        end else begin
                            // Line is overwritten in place, so it is invalid until word 3 lands.
                            r_ab           <= {cpu_addr[31:4], 4'h0};
                            r_mrd          <= 1'b0;
                            r_fill_cnt     <= '0;
                            r_valid[w_idx] <= 1'b0;
                            r_state        <= StFill;
                        end
                    end
                end
                StFill: begin
                    r_fill_cnt <= r_fill_cnt + 3'd1;
                    if (r_fill_cnt == 3'd3) begin
                        r_mrd <= 1'b1;
                    end
                    if (r_fill_cnt == 3'd4) begin
                        r_valid[r_idx] <= 1'b1;
                        r_state        <= StResp;
                    end
                end
                StResp: begin
                    r_rdata <= r_data[r_idx][r_word];
                    r_ready <= 1'b1;
                    r_state <= StDone;
                end
                StWrite: begin
                    if (r_hold == HOLDW'(WR_HOLD)) begin
                        r_mwr   <= 1'b0;
                        r_ready <= 1'b1;
                        r_state <= StDone;
                    end else begin
                        r_hold <= r_hold + HOLDW'(1);
                    end
                end
                StDone: begin
                    r_ready <= 1'b0;
                    r_state <= StIdle;
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign cpu_rdata = r_rdata;
    assign cpu_ready = r_ready;
    assign AB        = r_ab;
    assign DB        = r_db;
    assign MWr       = r_mwr;
    assign MRd       = r_mrd;

`ifdef CACHE_STATS_EN
    logic [15:0] r_hit_cnt;
    logic [15:0] r_miss_cnt;
    logic        w_rd_decide;

    // A read decision happens only in IDLE with a read and no competing write.
    assign w_rd_decide = (r_state == StIdle) && cpu_rd && !cpu_wr;

    // Saturating read hit/miss counters.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else if (w_rd_decide) begin
            if (w_hit) begin
                if (r_hit_cnt != 16'hFFFF) begin
                    r_hit_cnt <= r_hit_cnt + 16'd1;
                end
            end else begin
                if (r_miss_cnt != 16'hFFFF) begin
                    r_miss_cnt <= r_miss_cnt + 16'd1;
                end
            end
        end
    end

    assign hit_cnt  = r_hit_cnt;
    assign miss_cnt = r_miss_cnt;
`else
    assign hit_cnt  = 16'h0000;
    assign miss_cnt = 16'h0000;
`endif

endmodule
